// File: rtl/scan_addr_gen_if.sv
// scan_addr_gen_if: control/status bundle between a scan controller and
// scan_addr_gen. The controller (master) drives the scan configuration and
// start/stop; the generator (slave) returns the decoder select and status
// pulses.
interface scan_addr_gen_if #(
  parameter int DWELL_W = 8
);
  // Control, driven by the scan controller
  logic               START;
  logic               STOP;
  logic               DIR;
  logic               LOOP;
  logic               BOUNCE;
  logic [DWELL_W-1:0] DWELL;

  // Status and address, driven by the generator
  logic               A2;
  logic               A1;
  logic               A0;
  logic               BUSY;
  logic               STEP;
  logic               DONE;

  modport master (
    output START, STOP, DIR, LOOP, BOUNCE, DWELL,
    input  A2, A1, A0, BUSY, STEP, DONE
  );

  modport slave (
    input  START, STOP, DIR, LOOP, BOUNCE, DWELL,
    output A2, A1, A0, BUSY, STEP, DONE
  );
endinterface

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: 3-bit scan address generator feeding a 3-to-8 decoder.
// The address steps 0..7 or 7..0, holding each value for DWELL+1 cycles.
// A scan runs a single pass or loops, and STEP/DONE pulse on each advance
// and at each end of pass.
// Optional feature macro: PINGPONG_EN. When it is defined, a latched
// BOUNCE=1 reverses direction at the far end, so a pass runs out and back.
// When it is undefined, BOUNCE is ignored and no reversal logic exists.
module scan_addr_gen #(
  parameter int DWELL_W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  scan_addr_gen_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         addr_q,  addr_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q,   dir_d;   // current direction, 1 = down
  logic               loop_q,  loop_d;
  logic               step_q,  step_d;
  logic               done_q,  done_d;

`ifdef PINGPONG_EN
  logic               bounce_q, bounce_d;
  logic               turned_q, turned_d; // far-end turnaround already taken
`else
  // BOUNCE has no effect in this build.
  logic               unused_bounce;
  assign unused_bounce = bus.BOUNCE;
`endif

  logic               at_end;     // current address is last in current direction
  logic [2:0]         fwd_addr;   // one step in current direction (3-bit wrap)
  logic [2:0]         rev_addr;   // one step against current direction

  assign at_end   = dir_q ? (addr_q == 3'd0) : (addr_q == 3'd7);
  assign fwd_addr = dir_q ? (addr_q - 3'd1) : (addr_q + 3'd1);
  assign rev_addr = dir_q ? (addr_q + 3'd1) : (addr_q - 3'd1);

  // State and datapath registers, synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the previous cycle's values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= 3'd0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
      loop_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PINGPONG_EN
      bounce_q <= 1'b0;
      turned_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      dir_q    <= dir_d;
      loop_q   <= loop_d;
      step_q   <= step_d;
      done_q   <= done_d;
`ifdef PINGPONG_EN
      bounce_q <= bounce_d;
      turned_q <= turned_d;
`endif
    end
  end

  // Next-state, dwell counting and address advance.
  // NOTE: every signal gets a hold/idle default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    dir_d    = dir_q;
    loop_d   = loop_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
`ifdef PINGPONG_EN
    bounce_d = bounce_q;
    turned_d = turned_q;
`endif

    unique case (state_q)
      IDLE: begin
        // STOP alongside START keeps the generator idle.
        if (bus.START && !bus.STOP) begin
          dir_d    = bus.DIR;
          loop_d   = bus.LOOP;
          dwell_d  = bus.DWELL;
          addr_d   = bus.DIR ? 3'd7 : 3'd0;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef PINGPONG_EN
          bounce_d = bus.BOUNCE;
          turned_d = 1'b0;
`endif
        end
      end

      RUN: begin
        if (bus.STOP) begin
          // Abort wins over a coincident dwell expiry: address frozen.
          state_d = IDLE;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (!at_end) begin
            addr_d = fwd_addr;
            step_d = 1'b1;
`ifdef PINGPONG_EN
          end else if (bounce_q && !turned_q) begin
            // Far-end turnaround: reverse, no end of pass yet.
            dir_d    = !dir_q;
            addr_d   = rev_addr;
            turned_d = 1'b1;
            step_d   = 1'b1;
`endif
          end else begin
            // End of pass.
            done_d = 1'b1;
            if (loop_q) begin
              step_d = 1'b1;
`ifdef PINGPONG_EN
              if (bounce_q) begin
                // Back at the start address: turn again, start not repeated.
                dir_d    = !dir_q;
                addr_d   = rev_addr;
                turned_d = 1'b0;
              end else begin
                addr_d = fwd_addr;
              end
`else
              addr_d = fwd_addr;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.A2   = addr_q[2];
  assign bus.A1   = addr_q[1];
  assign bus.A0   = addr_q[0];
  assign bus.BUSY = (state_q == RUN);
  assign bus.STEP = step_q;
  assign bus.DONE = done_q;

endmodule

// File: doc/scan_addr_gen.md
# scan_addr_gen

- Generates the 3-bit select (A2,A1,A0) for the 3-to-8 decoder stage, which sits directly downstream.
- Steps the address through 0..7 or 7..0, holding each value for a programmable dwell time.
- Runs a single pass or loops continuously, with start/stop control, per-step and end-of-pass pulses.
- Used to scan one-hot decoder outputs (LED/row scanning).

## Interface
- DWELL_W, 8, width of dwell count input/counter
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  reset; one clock; reset is synchronous and active-high
- START  input  1  begin scan (sampled in IDLE only)
- STOP  input  1  abort scan
- DIR  input  1  0 = up (0→7), 1 = down (7→0); latched at START
- LOOP  input  1  1 = continuous, 0 = single pass; latched at START
- BOUNCE  input  1  ping-pong request; latched at START (see Configuration)
- DWELL  input  DWELL_W  cycles per address minus 1; latched at START
- A2, A1, A0  output  1 each  registered address, A2 = MSB, feeds decoder
- BUSY  output  1  high while in RUN
- STEP  output  1  one-cycle pulse on each address advance
- DONE  output  1  one-cycle pulse at end of each pass

## Operation
- States:
  - IDLE: BUSY=0, address held.
  - RUN: BUSY=1.
- Reset: state IDLE, A2..A0 = 000, BUSY/STEP/DONE = 0, dwell counter = 0, latched config cleared. Reset overrides all inputs.
- IDLE, START=1:
  - Latch DIR, LOOP, BOUNCE, DWELL.
  - Load address: 0 if up, 7 if down. Clear dwell counter. Go RUN. No STEP on load.
  - START with STOP both high in IDLE: stay IDLE.
- RUN:
  - Dwell counter increments every cycle.
  - When the counter equals the latched DWELL, it clears and the address advances (±1 per current direction).
  - Each address is held exactly DWELL+1 cycles. DWELL=0 advances every cycle.
- End of pass (advance due from the final address, 7 going up or 0 going down, no bounce):
  - LOOP=1: wrap (7→0 or 0→7), pulse STEP and DONE together, stay RUN.
  - LOOP=0: no advance, address holds final value. Pulse DONE (STEP=0), go IDLE.
- STOP in RUN:
  - Go IDLE next edge, address frozen at current value, no DONE/STEP.
  - STOP beats a coincident dwell expiry.
- START while in RUN is ignored. DWELL/DIR/LOOP/BOUNCE changes during RUN have no effect.
- Address arithmetic is 3-bit; wrap is the only overflow path.

## Timing
- START sampled at edge k: after edge k, address = start value, BUSY=1.
- First advance at edge k+DWELL+1. Nth advance at edge k+N·(DWELL+1).
- Single pass (no bounce): 8 addresses, BUSY high for 8·(DWELL+1) cycles. DONE high for the cycle after edge k+8·(DWELL+1); BUSY low in that same cycle.
- STEP/DONE/BUSY are registered and change only on CLK edges, aligned with the address update they describe.
- RST asserted mid-scan: next edge gives reset values. The scan does not resume.

## Configuration
- PINGPONG_EN defined:
  - Latched BOUNCE=1 reverses direction at the far end instead of wrapping.
  - Up-start pass: 0,1,…,7,6,…,0 (15 addresses). Down-start pass: 7,…,0,…,7.
  - End of pass occurs when an advance is due from the returned start address.
    - LOOP=0: stop there with DONE.
    - LOOP=1: pulse DONE with STEP and continue (0→1 or 7→6, start address not repeated).
  - Far-end turnaround pulses STEP only.
- PINGPONG_EN undefined: BOUNCE is ignored (treated as 0). No direction-reversal logic is synthesized. Behaviour is identical to BOUNCE=0.

## Test plan
- Reset: RST=1 for 2 cycles with START=1 → A=000, BUSY=0, STEP=0, DONE=0 throughout.
- Up single pass: DWELL=0, DIR=0, LOOP=0, START pulse → A = 0,1,…,7 on consecutive cycles, 7 STEP pulses. DONE=1 one cycle after A=7 held, A stays 7, BUSY falls.
- Down with dwell: DWELL=2, DIR=1, LOOP=1 → each address held 3 cycles, 7→0 then wrap to 7. STEP and DONE both pulse on the 0→7 edge. BUSY stays 1.
- Abort: DWELL=3, STOP asserted while A=4 on the same edge the dwell expires → A stays 4, BUSY=0, no STEP, no DONE. Subsequent START with DIR=0 reloads A=0.
- START ignored: START pulsed during RUN at A=2 → sequence unaffected.
- Ping-pong (PINGPONG_EN): DWELL=0, DIR=0, BOUNCE=1, LOOP=0 → A = 0..7..0 (15 values), 14 STEP pulses, one DONE, final A=0. Without the macro, same stimulus → plain 0..7 pass.
